control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 45 ++++
 rtl/control_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - opcode input, control outputs and state status of the control sequencer
interface control_sequencer_if;
  // opcode from the instruction register upper nibble
  logic [3:0] ToInstr;

  // fetch / memory controls
  logic       EnablePC;
  logic       IncrementPC;
  logic       LatchMAR;
  logic       EnableRAM;

  // instruction register controls
  logic       LatchInstrReg;
  logic       EnableInstrReg;

  // datapath controls
  logic       LatchAccA;
  logic       EnableAccA;
  logic       LatchRegB;
  logic       EnableALU;
  logic       Subtract;
  logic       LatchOut;

  // status
  logic [2:0] TState;
  logic       Halted;

  // sequencer side: consumes the opcode, drives controls and status
  modport master (
    input  ToInstr,
    output EnablePC, IncrementPC, LatchMAR, EnableRAM,
    output LatchInstrReg, EnableInstrReg,
    output LatchAccA, EnableAccA, LatchRegB, EnableALU, Subtract, LatchOut,
    output TState, Halted
  );

  // datapath side: supplies the opcode, receives controls and status
  modport slave (
    output ToInstr,
    input  EnablePC, IncrementPC, LatchMAR, EnableRAM,
    input  LatchInstrReg, EnableInstrReg,
    input  LatchAccA, EnableAccA, LatchRegB, EnableALU, Subtract, LatchOut,
    input  TState, Halted
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T1..T6 ring-counter control sequencer with HALT; SEQ_EARLY_END_EN enables early return to T1
module control_sequencer #(
  parameter logic [3:0] OUT_OP = 4'b1110,
  parameter logic [3:0] HLT_OP = 4'b1111
) (
  input  logic MainClock,
  input  logic ClearSeq,
  control_sequencer_if.master bus
);

  // TState encoding doubles as the state encoding: 1..6 = T1..T6, 0 = HALT
  localparam logic [2:0] ST_HALT = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_T5   = 3'd5;
  localparam logic [2:0] ST_T6   = 3'd6;

  localparam logic [3:0] LDA_OP = 4'b0000;
  localparam logic [3:0] ADD_OP = 4'b0001;
  localparam logic [3:0] SUB_OP = 4'b0010;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic is_hlt;
  logic is_out;
  logic is_lda;
  logic is_add;
  logic is_sub;
  logic early_end_t4;
  logic early_end_t5;

  // HLT and OUT take priority so a parameter override colliding with a
  // fixed opcode still gives one unambiguous decode
  assign is_hlt = (bus.ToInstr == HLT_OP);
  assign is_out = !is_hlt && (bus.ToInstr == OUT_OP);
  assign is_lda = !is_hlt && !is_out && (bus.ToInstr == LDA_OP);
  assign is_add = !is_hlt && !is_out && (bus.ToInstr == ADD_OP);
  assign is_sub = !is_hlt && !is_out && (bus.ToInstr == SUB_OP);

`ifdef SEQ_EARLY_END_EN
  // OUT and NOP have nothing left to do after T4, LDA after T5
  assign early_end_t4 = is_out || !(is_hlt || is_out || is_lda || is_add || is_sub);
  assign early_end_t5 = is_lda;
`else
  // every non-HLT instruction walks all six states
  assign early_end_t4 = 1'b0;
  assign early_end_t5 = 1'b0;
`endif

  // state register: ClearSeq forces T1 immediately, independent of the clock
  always_ff @(posedge MainClock or posedge ClearSeq) begin
    if (ClearSeq) begin
      state_q <= ST_T1;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: ring T1..T6, HLT exits to HALT from T4, HALT is absorbing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = ST_T4;
      ST_T4: begin
        if (is_hlt) begin
          state_d = ST_HALT;
        end else if (early_end_t4) begin
          state_d = ST_T1;
        end else begin
          state_d = ST_T5;
        end
      end
      ST_T5: begin
        if (early_end_t5) begin
          state_d = ST_T1;
        end else begin
          state_d = ST_T6;
        end
      end
      ST_T6:   state_d = ST_T1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_T1;
    endcase
  end

  // output decode: controls are a pure function of state and opcode,
  // forced quiet while ClearSeq is held so nothing latches during reset
  always_comb begin
    bus.EnablePC       = 1'b0;
    bus.IncrementPC    = 1'b0;
    bus.LatchMAR       = 1'b0;
    bus.EnableRAM      = 1'b0;
    bus.LatchInstrReg  = 1'b0;
    bus.EnableInstrReg = 1'b0;
    bus.LatchAccA      = 1'b0;
    bus.EnableAccA     = 1'b0;
    bus.LatchRegB      = 1'b0;
    bus.EnableALU      = 1'b0;
    bus.Subtract       = 1'b0;
    bus.LatchOut       = 1'b0;
    bus.TState         = state_q;
    bus.Halted         = (state_q == ST_HALT);

    if (ClearSeq) begin
      bus.TState = ST_T1;
      bus.Halted = 1'b0;
    end else begin
      case (state_q)
        ST_T1: begin
          bus.EnablePC = 1'b1;
          bus.LatchMAR = 1'b1;
        end
        ST_T2: begin
          bus.IncrementPC = 1'b1;
        end
        ST_T3: begin
          bus.EnableRAM     = 1'b1;
          bus.LatchInstrReg = 1'b1;
        end
        ST_T4: begin
          if (is_lda || is_add || is_sub) begin
            bus.EnableInstrReg = 1'b1;
            bus.LatchMAR       = 1'b1;
          end else if (is_out) begin
            bus.EnableAccA = 1'b1;
            bus.LatchOut   = 1'b1;
          end
        end
        ST_T5: begin
          if (is_lda) begin
            bus.EnableRAM = 1'b1;
            bus.LatchAccA = 1'b1;
          end else if (is_add || is_sub) begin
            bus.EnableRAM = 1'b1;
            bus.LatchRegB = 1'b1;
          end
        end
        ST_T6: begin
          if (is_add || is_sub) begin
            bus.EnableALU = 1'b1;
            bus.LatchAccA = 1'b1;
            bus.Subtract  = is_sub;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
